// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: operand forwarding selects, load-use and
// long-op stalls, a single-entry long-latency scoreboard and a saturating
// stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned LONG_LAT = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             IdValid,
    input  logic [4:0]       IdRs,
    input  logic [4:0]       IdRt,
    input  logic             IdUseRs,
    input  logic             IdUseRt,
    input  logic [4:0]       IdRd,
    input  logic             IdWb,
    input  logic             IdLong,
    input  logic             Flush,
    input  logic [31:0]      ExRdMask,
    input  logic [31:0]      MemRdMask,
    input  logic [31:0]      WbRdMask,
    input  logic             ExIsLoad,
    output logic [1:0]       FwdA,
    output logic [1:0]       FwdB,
    output logic             Stall,
    output logic             LongWbEn,
    output logic [4:0]       LongWbRd,
    output logic [31:0]      PendMask,
    output logic [CNT_W-1:0] StallCnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state, stateNext;
    logic [3:0]  cnt, cntNext;
    logic [4:0]  longRd, longRdNext;
    logic [31:0] pendMask, pendMaskNext;
    logic [CNT_W-1:0] stallCnt;

    logic [31:0] srcA, srcB, srcAny;
    logic        loadUse, pendHit, wawHit, structHit;
    logic        stallInt, issue, strobe;

    // EX hit on a load cannot forward (data not ready); it yields RF select
    // and the stall logic holds the instruction instead.
    function automatic logic [1:0] fwdSel(
        input logic [31:0] src,
        input logic [31:0] ex,
        input logic [31:0] mem,
        input logic [31:0] wb,
        input logic        exLoad
    );
        logic [1:0] sel;
        sel = 2'd0;
        if ((src & ex) != '0) begin
            sel = exLoad ? 2'd0 : 2'd1;
        end else if ((src & mem) != '0) begin
            sel = 2'd2;
        end else if ((src & wb) != '0) begin
            sel = 2'd3;
        end
        return sel;
    endfunction

    // One-hot source masks; register 0 never participates.
    always_comb begin
        srcA = '0;
        srcB = '0;
        if (IdValid && IdUseRs && (IdRs != 5'd0)) begin
            srcA = 32'd1 << IdRs;
        end
        if (IdValid && IdUseRt && (IdRt != 5'd0)) begin
            srcB = 32'd1 << IdRt;
        end
        srcAny = srcA | srcB;
    end

    // Forward selects, forced to RF while in reset.
    always_comb begin
        FwdA = 2'd0;
        FwdB = 2'd0;
        if (!Reset) begin
            FwdA = fwdSel(srcA, ExRdMask, MemRdMask, WbRdMask, ExIsLoad);
            FwdB = fwdSel(srcB, ExRdMask, MemRdMask, WbRdMask, ExIsLoad);
        end
    end

    // Hazard detection and the resulting stall / issue decisions.
    always_comb begin
        loadUse   = ExIsLoad && ((srcAny & ExRdMask) != '0);
        pendHit   = (srcAny & pendMask) != '0;
        wawHit    = IdWb && (IdRd != 5'd0) && pendMask[IdRd];
        structHit = IdLong && (state != IDLE);
        stallInt  = !Reset && !Flush && IdValid &&
                    (loadUse || pendHit || wawHit || structHit);
        issue     = (state == IDLE) && IdValid && IdLong && !stallInt && !Flush;
        strobe    = (state == BUSY) && (cnt == 4'd0);
    end

    // Long-op FSM next state: load on issue, count down, release on strobe.
    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        longRdNext   = longRd;
        pendMaskNext = pendMask;
        case (state)
            IDLE: begin
                if (issue) begin
                    stateNext    = BUSY;
                    cntNext      = 4'(LONG_LAT - 1);
                    longRdNext   = IdRd;
                    pendMaskNext = (IdRd != 5'd0) ? (32'd1 << IdRd) : '0;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    stateNext    = IDLE;
                    pendMaskNext = '0;
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end
            default: begin
                stateNext    = IDLE;
                cntNext      = '0;
                pendMaskNext = '0;
            end
        endcase
    end

    // Long-op FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            longRd   <= '0;
            pendMask <= '0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            longRd   <= longRdNext;
            pendMask <= pendMaskNext;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stallCnt <= '0;
        end else if (stallInt && (stallCnt != '1)) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end

    // Output drive; the strobe is suppressed in reset so a dropped op never pulses.
    always_comb begin
        Stall    = stallInt;
        LongWbEn = strobe && !Reset;
        LongWbRd = (strobe && !Reset) ? longRd : '0;
        PendMask = pendMask;
        StallCnt = stallCnt;
    end

endmodule
